// File: rtl/lease_multi_lookup_table.sv
`default_nettype none
// ============================================================================
// Module   : lease_multi_lookup_table
// Brief    : Associative address table returning one of several leases per
//            entry, picked by a 9-bit LFSR against cumulative probabilities.
// Revision : 1.0 - initial release
// ============================================================================
module lease_multi_lookup_table #(
    parameter int N_ENTRIES         = 128,
    parameter int N_LEASES          = 2,
    parameter int BW_LEASE_REGISTER = 32,
    parameter int BW_REF_ADDR       = 24,
    localparam int BW_ENTRIES       = $clog2(N_ENTRIES),
    localparam int BW_FIELD         = ($clog2(2 * N_LEASES) > 1) ? $clog2(2 * N_LEASES) : 1
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic [BW_ENTRIES-1:0]        cfg_addr_i,
    input  logic [BW_FIELD-1:0]          cfg_field_i,
    input  logic [31:0]                  cfg_data_i,
    input  logic                         cfg_wren_i,
    input  logic                         cfg_rmen_i,
    input  logic                         clear_i,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [BW_REF_ADDR-1:0]       req_addr_i,
    output logic                         resp_valid_o,
    input  logic                         resp_ready_i,
    output logic                         resp_hit_o,
    output logic [BW_LEASE_REGISTER-1:0] resp_lease_o,
    output logic [1:0]                   resp_lease_idx_o,
    output logic [31:0]                  hit_count_o,
    output logic [31:0]                  miss_count_o
);

    localparam int                 BW_PROB     = 9;
    localparam int                 c_N_PROBS   = (N_LEASES > 1) ? N_LEASES - 1 : 1;
    localparam int                 c_BW_CUM    = BW_PROB + 2;
    localparam logic [BW_PROB-1:0] c_LFSR_SEED = 9'h1FF;

    // ------------------------------------------------------------------------
    // Table storage (data is never reset; validity gates reachability)
    // ------------------------------------------------------------------------
    logic [N_ENTRIES-1:0]                       r_valid;
    logic [N_ENTRIES-1:0]                       w_valid_nxt;
    logic [BW_REF_ADDR-1:0]                     r_addr_mem [N_ENTRIES];
    logic [N_LEASES-1:0][BW_LEASE_REGISTER-1:0] w_rd_lease;
    logic [c_N_PROBS-1:0][BW_PROB-1:0]          w_rd_prob;
    logic                                       w_hit;
    logic [BW_ENTRIES-1:0]                      w_match_idx;

    always_ff @(posedge clock_i) begin
        if (cfg_wren_i && (cfg_field_i == '0)) begin
            r_addr_mem[cfg_addr_i] <= BW_REF_ADDR'(cfg_data_i);
        end
    end

    for (genvar k = 0; k < N_LEASES; k++) begin : g_lease
        logic [BW_LEASE_REGISTER-1:0] r_mem [N_ENTRIES];

        always_ff @(posedge clock_i) begin
            if (cfg_wren_i && (cfg_field_i == BW_FIELD'(k + 1))) begin
                r_mem[cfg_addr_i] <= BW_LEASE_REGISTER'(cfg_data_i);
            end
        end

        assign w_rd_lease[k] = r_mem[w_match_idx];
    end

    if (N_LEASES > 1) begin : g_probs
        for (genvar k = 0; k < N_LEASES - 1; k++) begin : g_prob
            logic [BW_PROB-1:0] r_mem [N_ENTRIES];

            always_ff @(posedge clock_i) begin
                if (cfg_wren_i && (cfg_field_i == BW_FIELD'(N_LEASES + 1 + k))) begin
                    r_mem[cfg_addr_i] <= BW_PROB'(cfg_data_i);
                end
            end

            assign w_rd_prob[k] = r_mem[w_match_idx];
        end
    end else begin : g_no_prob
        assign w_rd_prob = '0;
    end

    // Remove wins over a same-cycle lease-0 write; clear wins over both.
    always_comb begin
        w_valid_nxt = r_valid;
        if (cfg_wren_i && (cfg_field_i == BW_FIELD'(1))) begin
            w_valid_nxt[cfg_addr_i] = 1'b1;
        end
        if (cfg_rmen_i) begin
            w_valid_nxt[cfg_addr_i] = 1'b0;
        end
        if (clear_i) begin
            w_valid_nxt = '0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_valid <= '0;
        end else begin
            r_valid <= w_valid_nxt;
        end
    end

    // Scan downwards so the lowest matching index is the one left standing.
    always_comb begin
        w_hit       = 1'b0;
        w_match_idx = '0;
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_addr_mem[i] == req_addr_i)) begin
                w_hit       = 1'b1;
                w_match_idx = BW_ENTRIES'(i);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Pipeline flow control
    // ------------------------------------------------------------------------
    logic r_s1_valid;
    logic r_resp_valid;
    logic w_s1_free;
    logic w_s2_free;
    logic w_accept;
    logic w_resp_fire;

    assign w_s2_free   = !r_resp_valid || resp_ready_i;
    assign w_s1_free   = !r_s1_valid || w_s2_free;
    assign req_ready_o = !reset_i && w_s1_free;
    assign w_accept    = req_valid_i && req_ready_o;
    assign w_resp_fire = r_resp_valid && resp_ready_i;

    logic [BW_PROB-1:0] r_lfsr;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_lfsr <= c_LFSR_SEED;
        end else if (w_accept) begin
            r_lfsr <= {r_lfsr[BW_PROB-2:0], r_lfsr[8] ^ r_lfsr[4]};
        end
    end

    // ------------------------------------------------------------------------
    // Stage 1: registered compare result
    // ------------------------------------------------------------------------
    logic                                       r_s1_hit;
    logic [N_LEASES-1:0][BW_LEASE_REGISTER-1:0] r_s1_lease;
    logic [c_N_PROBS-1:0][BW_PROB-1:0]          r_s1_prob;
    logic [BW_PROB-1:0]                         r_s1_rnd;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_s1_valid <= 1'b0;
            r_s1_hit   <= 1'b0;
        end else if (w_s1_free) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_hit   <= w_hit;
                r_s1_lease <= w_rd_lease;
                r_s1_prob  <= w_rd_prob;
                r_s1_rnd   <= r_lfsr;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: lease selection by cumulative probability
    // ------------------------------------------------------------------------
    logic [c_BW_CUM-1:0]          w_cum;
    logic                         w_found;
    logic [1:0]                   w_sel_idx;
    logic [BW_LEASE_REGISTER-1:0] w_sel_lease;

    always_comb begin
        w_cum       = '0;
        w_found     = 1'b0;
        w_sel_idx   = 2'(N_LEASES - 1);
        w_sel_lease = r_s1_lease[N_LEASES-1];
        for (int k = 0; k < N_LEASES - 1; k++) begin
            w_cum = w_cum + c_BW_CUM'(r_s1_prob[k]);
            if (!w_found && ({2'b00, r_s1_rnd} <= w_cum)) begin
                w_found     = 1'b1;
                w_sel_idx   = 2'(k);
                w_sel_lease = r_s1_lease[k];
            end
        end
    end

    logic                         r_resp_hit;
    logic [BW_LEASE_REGISTER-1:0] r_resp_lease;
    logic [1:0]                   r_resp_idx;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_resp_valid <= 1'b0;
            r_resp_hit   <= 1'b0;
            r_resp_lease <= '0;
            r_resp_idx   <= '0;
        end else if (w_s2_free) begin
            r_resp_valid <= r_s1_valid;
            r_resp_hit   <= r_s1_valid && r_s1_hit;
            r_resp_lease <= (r_s1_valid && r_s1_hit) ? w_sel_lease : '0;
            r_resp_idx   <= (r_s1_valid && r_s1_hit) ? w_sel_idx : 2'b00;
        end
    end

    assign resp_valid_o     = r_resp_valid;
    assign resp_hit_o       = r_resp_hit;
    assign resp_lease_o     = r_resp_lease;
    assign resp_lease_idx_o = r_resp_idx;

    // ------------------------------------------------------------------------
    // Saturating response counters
    // ------------------------------------------------------------------------
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (w_resp_fire) begin
            if (r_resp_hit) begin
                if (r_hit_count != '1) begin
                    r_hit_count <= r_hit_count + 32'd1;
                end
            end else begin
                if (r_miss_count != '1) begin
                    r_miss_count <= r_miss_count + 32'd1;
                end
            end
        end
    end

    assign hit_count_o  = r_hit_count;
    assign miss_count_o = r_miss_count;

endmodule
`default_nettype wire

// File: tb/tb_lease_multi_lookup_table.sv
`default_nettype none
// ============================================================================
// Module   : tb_lease_multi_lookup_table
// Brief    : Directed self-checking bench with a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lease_multi_lookup_table;

    localparam int NE = 128;
    localparam int NL = 2;

    logic        clock_i    = 1'b0;
    logic        reset_i    = 1'b1;
    logic [6:0]  cfg_addr   = '0;
    logic [1:0]  cfg_field  = '0;
    logic [31:0] cfg_data   = '0;
    logic        cfg_wren   = 1'b0;
    logic        cfg_rmen   = 1'b0;
    logic        clear      = 1'b0;
    logic        req_valid  = 1'b0;
    logic [23:0] req_addr   = '0;
    logic        resp_ready = 1'b1;

    logic        req_ready;
    logic        resp_valid;
    logic        resp_hit;
    logic [31:0] resp_lease;
    logic [1:0]  resp_idx;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    lease_multi_lookup_table #(
        .N_ENTRIES         (NE),
        .N_LEASES          (NL),
        .BW_LEASE_REGISTER (32),
        .BW_REF_ADDR       (24)
    ) dut (
        .clock_i          (clock_i),
        .reset_i          (reset_i),
        .cfg_addr_i       (cfg_addr),
        .cfg_field_i      (cfg_field),
        .cfg_data_i       (cfg_data),
        .cfg_wren_i       (cfg_wren),
        .cfg_rmen_i       (cfg_rmen),
        .clear_i          (clear),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_addr_i       (req_addr),
        .resp_valid_o     (resp_valid),
        .resp_ready_i     (resp_ready),
        .resp_hit_o       (resp_hit),
        .resp_lease_o     (resp_lease),
        .resp_lease_idx_o (resp_idx),
        .hit_count_o      (hit_count),
        .miss_count_o     (miss_count)
    );

    always #5 clock_i = ~clock_i;

    int cyc = 0;
    always @(posedge clock_i) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int acc_cnt  = 0;
    bit armed    = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: table contents plus a queue of outstanding responses
    // ------------------------------------------------------------------------
    typedef struct {
        int          acc;
        bit          hit;
        logic [31:0] lease;
        logic [1:0]  idx;
    } exp_t;

    logic [23:0] m_addr  [NE];
    logic [31:0] m_lease [NE][NL];
    int          m_prob  [NE][NL];
    bit          m_valid [NE];
    logic [8:0]  m_r      = 9'h1FF;
    logic [31:0] m_hits   = '0;
    logic [31:0] m_misses = '0;
    exp_t        q[$];

    function automatic logic [8:0] lfsr_step(input logic [8:0] v);
        return {v[7:0], v[8] ^ v[4]};
    endfunction

    function automatic logic [1:0] pick(input logic [8:0] r, input int e);
        int cum = 0;
        for (int k = 0; k < NL - 1; k++) begin
            cum += m_prob[e][k];
            if (int'(r) <= cum) return 2'(k);
        end
        return 2'(NL - 1);
    endfunction

    task automatic model_cycle();
        bit   ev;
        bit   er;
        exp_t n;
        ev = (q.size() > 0) && (cyc >= q[0].acc + 2);
        er = !reset_i && !((q.size() >= 2) && !resp_ready);
        check("req_ready", req_ready, er);
        check("resp_valid", resp_valid, ev);
        check("hit_count", hit_count, m_hits);
        check("miss_count", miss_count, m_misses);
        if (ev) begin
            check("resp_hit", resp_hit, q[0].hit);
            check("resp_lease", resp_lease, q[0].lease);
            check("resp_idx", resp_idx, q[0].idx);
        end
        if (reset_i) begin
            q.delete();
            m_hits   = '0;
            m_misses = '0;
            m_r      = 9'h1FF;
            foreach (m_valid[e]) m_valid[e] = 1'b0;
            return;
        end
        if (ev && resp_ready) begin
            if (q[0].hit) begin
                if (m_hits != 32'hFFFFFFFF) m_hits++;
            end else begin
                if (m_misses != 32'hFFFFFFFF) m_misses++;
            end
            void'(q.pop_front());
        end
        if (req_valid && er) begin
            n.acc   = cyc;
            n.hit   = 1'b0;
            n.lease = '0;
            n.idx   = '0;
            for (int e = 0; e < NE; e++) begin
                if (!n.hit && m_valid[e] && (m_addr[e] == req_addr)) begin
                    n.hit   = 1'b1;
                    n.idx   = pick(m_r, e);
                    n.lease = m_lease[e][n.idx];
                end
            end
            q.push_back(n);
            m_r = lfsr_step(m_r);
            acc_cnt++;
        end
        if (cfg_wren) begin
            if (cfg_field == 2'd0) begin
                m_addr[cfg_addr] = cfg_data[23:0];
            end else if (int'(cfg_field) <= NL) begin
                m_lease[cfg_addr][int'(cfg_field) - 1] = cfg_data;
                if (cfg_field == 2'd1) m_valid[cfg_addr] = 1'b1;
            end else begin
                m_prob[cfg_addr][int'(cfg_field) - NL - 1] = int'(cfg_data[8:0]);
            end
        end
        if (cfg_rmen) m_valid[cfg_addr] = 1'b0;
        if (clear) foreach (m_valid[e]) m_valid[e] = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clock_i);
            if (armed) model_cycle();
        end
    end

    // ------------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic cfg_write(input logic [6:0] a, input logic [1:0] f, input logic [31:0] d);
        cfg_addr  = a;
        cfg_field = f;
        cfg_data  = d;
        cfg_wren  = 1'b1;
        tick();
        cfg_wren  = 1'b0;
    endtask

    task automatic lookup(input string name, input logic [23:0] a, input logic h,
                          input logic [31:0] l, input logic [1:0] i);
        req_valid = 1'b1;
        req_addr  = a;
        tick();
        req_valid = 1'b0;
        tick();
        check({name, "_valid"}, resp_valid, 1'b1);
        check({name, "_hit"}, resp_hit, h);
        check({name, "_lease"}, resp_lease, l);
        check({name, "_idx"}, resp_idx, i);
        tick();
    endtask

    logic [23:0] addrs [3];
    int n;
    int base;

    initial begin
        addrs[0] = 24'h00ABCD;
        addrs[1] = 24'h000001;
        addrs[2] = 24'h00ABCD;
        check("lfsr_model_step", lfsr_step(9'h1FF), 9'h1FE);

        @(posedge clock_i);
        #1;
        armed = 1'b1;
        check("reset_ready_low", req_ready, 1'b0);
        tick();
        reset_i = 1'b0;
        #1;
        check("release_ready", req_ready, 1'b1);
        check("reset_resp_valid", resp_valid, 1'b0);
        check("reset_lease", resp_lease, 32'd0);
        check("reset_hits", hit_count, 32'd0);

        // Basic hit with prob0 = 511 always picks lease 0
        cfg_write(7'd5, 2'd0, 32'h0000ABCD);
        cfg_write(7'd5, 2'd1, 32'd100);
        cfg_write(7'd5, 2'd2, 32'd7);
        cfg_write(7'd5, 2'd3, 32'd511);
        lookup("basic", 24'h00ABCD, 1'b1, 32'd100, 2'd0);

        // prob0 = 0 never covers r >= 1, so lease 1 always
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        cfg_write(7'd5, 2'd1, 32'd100);
        cfg_write(7'd5, 2'd3, 32'd0);
        req_valid = 1'b1;
        req_addr  = 24'h00ABCD;
        repeat (600) tick();
        req_valid = 1'b0;
        repeat (3) tick();
        check("b2b_hit_count", hit_count, 32'd600);
        check("b2b_miss_count", miss_count, 32'd0);

        // Clear then miss
        clear = 1'b1;
        tick();
        clear = 1'b0;
        lookup("miss", 24'h000001, 1'b0, 32'd0, 2'd0);
        check("miss_count_one", miss_count, 32'd1);
        check("hits_kept", hit_count, 32'd600);

        // Remove in the acceptance cycle still sees the old table
        cfg_write(7'd5, 2'd1, 32'd100);
        cfg_addr  = 7'd5;
        cfg_rmen  = 1'b1;
        req_valid = 1'b1;
        req_addr  = 24'h00ABCD;
        tick();
        cfg_rmen = 1'b0;
        tick();
        req_valid = 1'b0;
        check("rm_same_hit", resp_hit, 1'b1);
        check("rm_same_lease", resp_lease, 32'd7);
        tick();
        check("rm_next_valid", resp_valid, 1'b1);
        check("rm_next_hit", resp_hit, 1'b0);
        tick();

        // Write and remove together leaves the entry invalid
        cfg_write(7'd6, 2'd0, 32'h66);
        cfg_addr  = 7'd6;
        cfg_field = 2'd1;
        cfg_data  = 32'd9;
        cfg_wren  = 1'b1;
        cfg_rmen  = 1'b1;
        tick();
        cfg_wren = 1'b0;
        cfg_rmen = 1'b0;
        lookup("wr_rm", 24'h000066, 1'b0, 32'd0, 2'd0);

        // Lowest index wins among duplicates
        cfg_write(7'd9, 2'd0, 32'h0000ABCD);
        cfg_write(7'd9, 2'd1, 32'd77);
        cfg_write(7'd7, 2'd0, 32'h0000ABCD);
        cfg_write(7'd7, 2'd1, 32'd55);
        cfg_write(7'd7, 2'd3, 32'd511);
        lookup("lowest", 24'h00ABCD, 1'b1, 32'd55, 2'd0);

        // Backpressure: three offered, two fit while stalled
        base       = acc_cnt;
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_addr   = addrs[0];
        for (int i = 0; i < 5; i++) begin
            tick();
            n = acc_cnt - base;
            if (n < 3) req_addr = addrs[n];
            else req_valid = 1'b0;
        end
        check("stall_accepts", acc_cnt - base, 2);
        check("stall_ready", req_ready, 1'b0);
        check("stall_hold_lease", resp_lease, 32'd55);
        resp_ready = 1'b1;
        for (int i = 0; (i < 10) && req_valid; i++) begin
            tick();
            n = acc_cnt - base;
            if (n < 3) req_addr = addrs[n];
            else req_valid = 1'b0;
        end
        req_valid = 1'b0;
        repeat (4) tick();
        check("stall_total", acc_cnt - base, 3);

        // Reset with two lookups in flight
        clear = 1'b1;
        tick();
        clear = 1'b0;
        cfg_write(7'd5, 2'd3, 32'd510);
        cfg_write(7'd5, 2'd1, 32'd100);
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_addr   = 24'h00ABCD;
        tick();
        tick();
        req_valid = 1'b0;
        reset_i   = 1'b1;
        tick();
        reset_i    = 1'b0;
        resp_ready = 1'b1;
        #1;
        check("rst_flush_valid", resp_valid, 1'b0);
        check("rst_hits", hit_count, 32'd0);
        check("rst_misses", miss_count, 32'd0);
        check("rst_ready", req_ready, 1'b1);
        repeat (3) tick();
        check("rst_no_resp", resp_valid, 1'b0);
        cfg_write(7'd5, 2'd1, 32'd100);
        req_valid = 1'b1;
        req_addr  = 24'h00ABCD;
        tick();
        tick();
        req_valid = 1'b0;
        check("seed_r1ff_lease", resp_lease, 32'd7);
        check("seed_r1ff_idx", resp_idx, 2'd1);
        tick();
        check("seed_r1fe_lease", resp_lease, 32'd100);
        check("seed_r1fe_idx", resp_idx, 2'd0);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lease_multi_lookup_table.md
LEASE_MULTI_LOOKUP_TABLE -- requirements
Module: lease_multi_lookup_table

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clock_i and reset_i.
REQ-002 Parameter N_ENTRIES, default 128, SHALL set the table depth and SHALL be a power of two; BW_ENTRIES = CLOG2(N_ENTRIES).
REQ-003 Parameter N_LEASES, default 2, range 1..4, SHALL set the number of lease values per entry.
REQ-004 Parameter BW_LEASE_REGISTER, default 32, SHALL set the lease value width.
REQ-005 Parameter BW_REF_ADDR, default 24, SHALL set the reference address width.
REQ-006 Parameter BW_PROB, fixed at 9, SHALL set the probability field width to match the 9-bit LFSR.
REQ-007 Ports SHALL be (name  direction  width  meaning):
- clock_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- cfg_addr_i  in  BW_ENTRIES  entry index for config access
- cfg_field_i  in  BW_FIELD=max(1,CLOG2(2*N_LEASES))  0=ref addr, 1..N_LEASES=lease k-1, N_LEASES+1..2*N_LEASES-1=prob k-N_LEASES-1
- cfg_data_i  in  32  write data, LSB-aligned and truncated to field width
- cfg_wren_i  in  1  write cfg_data_i to the selected field
- cfg_rmen_i  in  1  invalidate entry cfg_addr_i
- clear_i  in  1  invalidate all entries
- req_valid_i / req_ready_o  in / out  1  lookup request handshake
- req_addr_i  in  BW_REF_ADDR  address to look up
- resp_valid_o / resp_ready_i  out / in  1  lookup response handshake
- resp_hit_o  out  1  the looked-up address is in the table
- resp_lease_o  out  BW_LEASE_REGISTER  selected lease
- resp_lease_idx_o  out  2  index of the selected lease
- hit_count_o, miss_count_o  out  32  saturating response counters

Function
REQ-008 An entry SHALL become valid on a write to field 1 (lease 0); a write to any other field SHALL NOT change validity.
REQ-009 If cfg_wren_i and cfg_rmen_i address the same entry in the same cycle, the data SHALL be written and the entry SHALL end invalid.
REQ-010 On clear_i, all valid bits SHALL be 0 on the next cycle; stored data, counters and in-flight lookups SHALL be unaffected.
REQ-011 The lookup SHALL be a 2-stage pipeline.
- S1 accepts a request when req_valid_i && req_ready_o, compares the address against all valid entries, and registers the hit, the matched entry's leases and its probabilities.
- S2 selects the lease and presents the response.
REQ-012 Latency SHALL be fixed: a request accepted at cycle T SHALL give resp_valid_o=1 at T+2 when there is no backpressure.
REQ-013 The block SHALL accept one request per cycle while resp_ready_i=1; req_ready_o SHALL be 0 only when S2 holds a response with resp_ready_i=0 and S1 is also occupied.
REQ-014 While resp_valid_o=1 && resp_ready_i=0, all resp_* outputs SHALL hold stable.
REQ-015 The compare SHALL use table state from before any config write or clear in the acceptance cycle.
REQ-016 If several entries match, the lowest index SHALL win.
REQ-017 The LFSR SHALL be 9 bits, with taps x^9+x^5+1, seed 9'h1FF, value range 1..511, and SHALL advance once per accepted request; the request accepted in a cycle SHALL use the pre-advance value r.
REQ-018 Lease selection: C_k = sum of prob_0..prob_k, computed at 11-bit width with no wrap. The selected index SHALL be the smallest k < N_LEASES-1 with r <= C_k, else N_LEASES-1. With N_LEASES=1 the selected index SHALL always be 0.
REQ-019 On a miss: resp_hit_o=0, resp_lease_o=0, resp_lease_idx_o=0.
REQ-020 On each response handshake, hit_count_o or miss_count_o SHALL increment by 1 and saturate at 32'hFFFFFFFF.

Reset
REQ-021 While reset_i=1 at a clock edge, the following SHALL be cleared: all valid bits to 0, pipeline empty, resp_valid_o=0, resp_hit_o=0, resp_lease_o=0, resp_lease_idx_o=0, counters 0, LFSR 9'h1FF. req_ready_o SHALL be 0 while reset_i=1 and 1 in the first cycle after release.
REQ-022 A reset asserted mid-operation SHALL discard in-flight lookups with no response.
REQ-023 Table data SHALL NOT be cleared by reset; it SHALL be unreachable until rewritten, because every entry is invalid.

Verification
REQ-024 Configuration, N_LEASES=2: entry 5 = {addr 24'h00ABCD, lease0 100, lease1 7, prob0 511}; request 24'h00ABCD at T -> at T+2: hit=1, lease=100, idx=0.
REQ-025 Same entry with prob0=0; 600 back-to-back requests -> every response: hit=1, lease=7, idx=1; hit_count_o=600.
REQ-026 Request 24'h000001 with an empty table -> hit=0, lease=0, idx=0; miss_count_o increments by exactly 1.
REQ-027 Hold resp_ready_i=0 for 5 cycles with 3 requests offered -> req_ready_o drops after 2 are accepted, outputs stay stable, and all 3 responses arrive in order once resp_ready_i=1.
REQ-028 Same-cycle cases:
- cfg_rmen_i on entry 5 in the same cycle as a request for its address -> that response is hit=1; the next request gets hit=0.
- cfg_wren_i and cfg_rmen_i on the same entry -> the entry ends invalid.
REQ-029 Assert reset_i for 1 cycle with 2 lookups in flight -> no responses, counters=0, and the first request after release uses r=9'h1FF.
